// File: rtl/alu_dispatch.sv
// Issue-side sequencer for the RV32I ALU: accepts one instruction, decodes it, drives the
// external ALU from a 32x32 register file and writes the result back. Optional ALU_DISPATCH_FAST_EN.
module alu_dispatch (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [5:0]  alu_op,
  output logic [31:0] alu_rs1,
  output logic [31:0] alu_rs2,
  input  logic [31:0] alu_wd,
  output logic        done,
  output logic        illegal,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPW   = 6;
  localparam int unsigned NREGS = 32;

`ifdef ALU_DISPATCH_FAST_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  localparam logic [OPW-1:0] OP_NONE = 6'd0;
  localparam logic [OPW-1:0] OP_ADD  = 6'd1;
  localparam logic [OPW-1:0] OP_SUB  = 6'd2;
  localparam logic [OPW-1:0] OP_XOR  = 6'd3;
  localparam logic [OPW-1:0] OP_OR   = 6'd4;
  localparam logic [OPW-1:0] OP_AND  = 6'd5;
  localparam logic [OPW-1:0] OP_SLL  = 6'd6;
  localparam logic [OPW-1:0] OP_SRA  = 6'd7;
  localparam logic [OPW-1:0] OP_SRL  = 6'd8;
  localparam logic [OPW-1:0] OP_SLT  = 6'd9;
  localparam logic [OPW-1:0] OP_SLTU = 6'd10;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic           illegal;
    logic           use_imm;
  } dec_t;

  // Instruction word to ALU op; anything outside R-type and ADDI is illegal with op 0.
  function automatic dec_t decode(input logic [XLEN-1:0] instr);
    dec_t d;
    d.op      = OP_NONE;
    d.illegal = 1'b1;
    d.use_imm = 1'b0;
    if (instr[6:0] == 7'b0110011) begin
      if (instr[31:25] == 7'b0000000) begin
        d.illegal = 1'b0;
        case (instr[14:12])
          3'b000:  d.op = OP_ADD;
          3'b001:  d.op = OP_SLL;
          3'b010:  d.op = OP_SLT;
          3'b011:  d.op = OP_SLTU;
          3'b100:  d.op = OP_XOR;
          3'b101:  d.op = OP_SRL;
          3'b110:  d.op = OP_OR;
          default: d.op = OP_AND;
        endcase
      end else if (instr[31:25] == 7'b0100000) begin
        case (instr[14:12])
          3'b000: begin
            d.op      = OP_SUB;
            d.illegal = 1'b0;
          end
          3'b101: begin
            d.op      = OP_SRA;
            d.illegal = 1'b0;
          end
          default: d.op = OP_NONE;
        endcase
      end
    end else if (instr[6:0] == 7'b0010011 && instr[14:12] == 3'b000) begin
      d.op      = OP_ADD;
      d.illegal = 1'b0;
      d.use_imm = 1'b1;
    end
    return d;
  endfunction

  state_t            state_q, state_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [OPW-1:0]    alu_op_q, alu_op_d;
  logic [XLEN-1:0]   alu_rs1_q, alu_rs1_d;
  logic [XLEN-1:0]   alu_rs2_q, alu_rs2_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic              in_ready_q, in_ready_d;
  logic              rf_we;
  logic              opnd_ld;
  logic [XLEN-1:0]   rf_q [NREGS];

  // The fast build reads operands from the word being accepted; otherwise from the latched word.
  logic [XLEN-1:0] src_instr;
  logic [XLEN-1:0] src_imm;
  dec_t            ld_dec;
  dec_t            wb_dec;

  assign src_instr = FAST_EN ? in_instr : instr_q;
  assign src_imm   = {{(XLEN-12){src_instr[31]}}, src_instr[31:20]};
  assign ld_dec    = decode(src_instr);
  assign wb_dec    = decode(instr_q);

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    alu_op_d   = alu_op_q;
    alu_rs1_d  = alu_rs1_q;
    alu_rs2_d  = alu_rs2_q;
    res_d      = res_q;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    rf_we      = 1'b0;
    opnd_ld    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          instr_d = in_instr;
          if (FAST_EN) begin
            state_d = S_EXEC;
            opnd_ld = 1'b1;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        state_d = S_EXEC;
        opnd_ld = 1'b1;
      end
      S_EXEC: begin
        res_d   = alu_wd;
        state_d = S_WB;
      end
      S_WB: begin
        state_d   = S_IDLE;
        done_d    = 1'b1;
        illegal_d = wb_dec.illegal;
        rf_we     = !wb_dec.illegal && (instr_q[11:7] != 5'd0);
      end
      default: state_d = S_IDLE;
    endcase
    if (opnd_ld) begin
      alu_op_d  = ld_dec.op;
      alu_rs1_d = rf_q[src_instr[19:15]];
      alu_rs2_d = ld_dec.use_imm ? src_imm : rf_q[src_instr[24:20]];
    end
    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      alu_op_q   <= OP_NONE;
      alu_rs1_q  <= '0;
      alu_rs2_q  <= '0;
      res_q      <= '0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      alu_op_q   <= alu_op_d;
      alu_rs1_q  <= alu_rs1_d;
      alu_rs2_q  <= alu_rs2_d;
      res_q      <= res_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[instr_q[11:7]] <= res_q;
    end
  end

  assign in_ready = in_ready_q;
  assign alu_op   = alu_op_q;
  assign alu_rs1  = alu_rs1_q;
  assign alu_rs2  = alu_rs2_q;
  assign done     = done_q;
  assign illegal  = illegal_q;
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_dispatch.sv
// Self-checking bench for alu_dispatch: directed program plus random instruction stream
// against an instruction-level register-file model; also models the external ALU.
module tb_alu_dispatch;

`ifdef ALU_DISPATCH_FAST_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 4;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [5:0]  alu_op;
  logic [31:0] alu_rs1;
  logic [31:0] alu_rs2;
  logic [31:0] alu_wd;
  logic        done;
  logic        illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  always #5 clk = ~clk;

  alu_dispatch dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_instr (in_instr),
    .alu_op   (alu_op),
    .alu_rs1  (alu_rs1),
    .alu_rs2  (alu_rs2),
    .alu_wd   (alu_wd),
    .done     (done),
    .illegal  (illegal),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // External combinational ALU, keyed on the op code table.
  always_comb begin
    case (alu_op)
      6'd1:    alu_wd = alu_rs1 + alu_rs2;
      6'd2:    alu_wd = alu_rs1 - alu_rs2;
      6'd3:    alu_wd = alu_rs1 ^ alu_rs2;
      6'd4:    alu_wd = alu_rs1 | alu_rs2;
      6'd5:    alu_wd = alu_rs1 & alu_rs2;
      6'd6:    alu_wd = alu_rs1 << alu_rs2[4:0];
      6'd7:    alu_wd = 32'($signed(alu_rs1) >>> alu_rs2[4:0]);
      6'd8:    alu_wd = alu_rs1 >> alu_rs2[4:0];
      6'd9:    alu_wd = ($signed(alu_rs1) < $signed(alu_rs2)) ? 32'd1 : 32'd0;
      6'd10:   alu_wd = (alu_rs1 < alu_rs2) ? 32'd1 : 32'd0;
      default: alu_wd = 32'd0;
    endcase
  end

  logic [31:0] ref_rf [32];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Architectural effect of one instruction, from RV32I semantics.
  task automatic ref_eval(input logic [31:0] ins, output bit legal, output logic [5:0] op,
                          output logic [31:0] a, output logic [31:0] b, output logic [31:0] r);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = ins[31:25];
    f3 = ins[14:12];
    a = ref_rf[ins[19:15]];
    b = ref_rf[ins[24:20]];
    legal = 1'b0;
    op = 6'd0;
    r = 32'd0;
    if (ins[6:0] == 7'h33 && (f7 == 7'h00 || f7 == 7'h20)) begin
      legal = 1'b1;
      case ({f7[5], f3})
        4'b0000: begin op = 6'd1;  r = a + b; end
        4'b1000: begin op = 6'd2;  r = a - b; end
        4'b0001: begin op = 6'd6;  r = a << b[4:0]; end
        4'b0010: begin op = 6'd9;  r = {31'd0, $signed(a) < $signed(b)}; end
        4'b0011: begin op = 6'd10; r = {31'd0, a < b}; end
        4'b0100: begin op = 6'd3;  r = a ^ b; end
        4'b0101: begin op = 6'd8;  r = a >> b[4:0]; end
        4'b1101: begin op = 6'd7;  r = 32'($signed(a) >>> b[4:0]); end
        4'b0110: begin op = 6'd4;  r = a | b; end
        4'b0111: begin op = 6'd5;  r = a & b; end
        default: legal = 1'b0;
      endcase
    end else if (ins[6:0] == 7'h13 && f3 == 3'b000) begin
      legal = 1'b1;
      op = 6'd1;
      b = {{20{ins[31]}}, ins[31:20]};
      r = a + b;
    end
  endtask

  // Issue one instruction and follow it to retirement; returns at the done-cycle negedge.
  task automatic run(input logic [31:0] ins, input bit hold_valid);
    bit          legal;
    bit          seen;
    logic [5:0]  op;
    logic [31:0] a, b, r;
    int          cyc;
    ref_eval(ins, legal, op, a, b, r);
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("ready_before_issue", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_instr = ins;
    @(posedge clk);
    #1;
    in_instr = $urandom();
    in_valid = hold_valid;
    seen = 1'b0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(negedge clk);
      if (k == LAT - 2) begin
        check("exec_op", 32'(alu_op), 32'(op));
        if (legal) begin
          check("exec_rs1", alu_rs1, a);
          check("exec_rs2", alu_rs2, b);
        end
      end
      if (k == LAT - 1) check("wb_op_hold", 32'(alu_op), 32'(op));
      if (k < LAT) check("busy_not_ready", 32'(in_ready), 32'd0);
      if (done) begin
        seen = 1'b1;
        check("done_latency", 32'(k), 32'(LAT));
        check("illegal_flag", 32'(illegal), 32'(!legal));
        check("ready_with_done", 32'(in_ready), 32'd1);
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    if (legal && ins[11:7] != 5'd0) ref_rf[ins[11:7]] = r;
    dbg_addr = ins[11:7];
    #1;
    check("wb_rd", dbg_data, ref_rf[ins[11:7]]);
  endtask

  task automatic sweep();
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      check($sformatf("rf_x%0d", i), dbg_data, ref_rf[i]);
    end
  endtask

  task automatic rf_expect(input int idx, input logic [31:0] val);
    dbg_addr = 5'(idx);
    #1;
    check($sformatf("spec_x%0d", idx), dbg_data, val);
  endtask

  // Start an instruction and reset it at the k-th negedge after acceptance.
  task automatic rst_during(input logic [31:0] ins, input int kat);
    bit saw_done;
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b1;
    in_instr = ins;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 1; k <= kat; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_ready", 32'(in_ready), 32'd1);
    saw_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("rst_mid_no_done", 32'(saw_done), 32'd0);
    sweep();
  endtask

  logic [3:0] rkeys [10] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                             4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [4:0]  rd, rs1, rs2;
    logic [3:0]  key;
    int          sel;
    sel = int'($urandom_range(0, 9));
    rd  = 5'($urandom());
    rs1 = 5'($urandom());
    rs2 = 5'($urandom());
    key = rkeys[$urandom_range(0, 9)];
    if (sel < 4)
      w = {key[3] ? 7'h20 : 7'h00, rs2, rs1, key[2:0], rd, 7'h33};
    else if (sel < 7)
      w = {12'($urandom()), rs1, 3'b000, rd, 7'h13};
    else if (sel == 7)
      w = {7'($urandom()), rs2, rs1, key[2:0], rd, 7'h33};
    else if (sel == 8)
      w = $urandom();
    else
      w = {12'($urandom()), rs1, 3'($urandom()), rd, 7'h13};
    return w;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = 32'd0;
    dbg_addr = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_op", 32'(alu_op), 32'd0);
    check("rst_rs1", alu_rs1, 32'd0);
    check("rst_rs2", alu_rs2, 32'd0);
    sweep();

    run(32'h00500093, 1'b0);
    rf_expect(1, 32'h00000005);
    run(32'hFFD00113, 1'b1);
    run(32'h002081B3, 1'b0);
    rf_expect(2, 32'hFFFFFFFD);
    rf_expect(3, 32'h00000002);
    run(32'h0020A233, 1'b1);
    run(32'h0020B2B3, 1'b0);
    rf_expect(4, 32'h00000000);
    rf_expect(5, 32'h00000001);
    run(32'h40208033, 1'b0);
    rf_expect(0, 32'h00000000);
    sweep();
    run(32'h0000007F, 1'b1);
    sweep();

    rst_during(32'h00700313, LAT - 2);
    rf_expect(6, 32'h00000000);
    rf_expect(1, 32'h00000000);
    run(32'h00500093, 1'b0);
    rst_during(32'h00700313, LAT - 1);

    for (int n = 0; n < 120; n++) begin
      run(gen_instr(), 1'($urandom()));
      if (n % 20 == 19) sweep();
    end
    sweep();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
